instr_fetch_decode: RTL
=======================

Name: instr_fetch_decode

Overview:
- Instruction-side counterpart to the 4-bit program counter. Takes the PC value, fetches an 8-bit instruction from instruction memory over a req/ready handshake, and latches it in an instruction register (IR).
- Decodes the IR into the PC control fields (PL, JB, BC, LAddress, RAddress) and the datapath controls (DA/AA/BA/MB/FS/MD/RW/MW).
- Multi-cycle controller. Controls are valid for exactly one EXEC cycle per instruction.

Parameters:
- AW, 4, PC/instruction-memory address width.
- IW, 8, instruction width: opcode[7:4], LAddress/DR[3:2], RAddress/SB[1:0].
- TIMEOUT, 15, maximum WAIT cycles before a fetch error; counter width is clog2(TIMEOUT+1).

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- PC  in  AW  current program counter value.
- IMEM_REQ  out  1  fetch request; held until IMEM_RDY.
- IMEM_ADDR  out  AW  fetch address; registered copy of PC at fetch start.
- IMEM_RDY  in  1  memory data valid this cycle.
- IMEM_DATA  in  IW  instruction word; sampled when IMEM_REQ&IMEM_RDY.
- CTRL_VALID  out  1  one-cycle strobe; all control outputs below are meaningful only while high.
- PL, JB, BC  out  1 each  PC control.
- LAddress, RAddress  out  2 each  IR[3:2], IR[1:0].
- DA, AA, BA  out  2 each  destination = IR[3:2], A = IR[3:2], B = IR[1:0].
- MB  out  1  1 = immediate (zero-extended RAddress) on B bus.
- FS  out  4  ALU function select.
- MD  out  1  1 = memory data to register file.
- RW, MW  out  1 each  register write / data-memory write.
- HALTED  out  1  level; core halted.
- FETCH_ERR  out  1  sticky; timeout occurred.

Behaviour:
- Reset (async, RST_N=0):
  - State=FETCH, IR=0, timeout counter=0.
  - All outputs 0, including IMEM_REQ, CTRL_VALID, HALTED, FETCH_ERR.
  - Takes effect mid-handshake; any in-flight IMEM_RDY is ignored after release.
- FETCH (1 cycle): latch IMEM_ADDR<=PC, assert IMEM_REQ, counter=0 -> WAIT.
- WAIT:
  - IMEM_REQ=1 and IMEM_ADDR stable.
  - On IMEM_RDY: IR<=IMEM_DATA, deassert IMEM_REQ next cycle -> DECODE.
  - Otherwise the counter increments. When counter==TIMEOUT: FETCH_ERR<=1, IMEM_REQ<=0 -> HALT.
  - IMEM_RDY in the same cycle the counter reaches TIMEOUT: data wins, no error.
  - Minimum latency PC->CTRL_VALID is 4 cycles (FETCH, WAIT with RDY, DECODE, EXEC).
- DECODE (1 cycle): combinational decode of IR registered into the control outputs -> EXEC.
- EXEC (1 cycle): CTRL_VALID=1. PC block samples its controls on this edge -> FETCH. Outputs return to 0 afterwards.
- HALT: absorbing. HALTED=1, no requests. Exit only via reset.
- IMEM_RDY outside WAIT is ignored.
- Decode table (opcode: FS, RW, MB, MD, MW, PL, JB, BC); all unlisted fields 0:
  - 0 NOP: all 0.
  - 1 MOVA: FS=0000, RW=1.
  - 2 INC: FS=0001, RW=1.
  - 3 ADD: FS=0010, RW=1.
  - 4 SUB: FS=0101, RW=1.
  - 5 AND: FS=1000, RW=1.
  - 6 OR: FS=1001, RW=1.
  - 7 XOR: FS=1010, RW=1.
  - 8 LDI: FS=1100, RW=1, MB=1.
  - 9 ADI: FS=0010, RW=1, MB=1.
  - A LD: MD=1, RW=1.
  - B ST: MW=1.
  - C BRZ: PL=1, BC=0.
  - D BRN: PL=1, BC=1.
  - E JMP: PL=1, JB=1.
  - F HALT: no CTRL_VALID; DECODE -> HALT.
- Branch offset (LAddress,RAddress) is 4-bit and added by the PC block modulo 16. This block never modifies PC.

Decomposition:
- Package fetch_pkg holds:
  - State enum {FETCH, WAIT, DECODE, EXEC, HALT}.
  - Opcode constants OP_NOP..OP_HALT.
  - FS codes FS_MOV, FS_INC, FS_ADD, FS_SUB, FS_AND, FS_OR, FS_XOR, FS_PASSB.
  - Field bit positions.
- One sub-module, instr_decoder: purely combinational, IR in -> control bundle out, unit-testable against the table.
- FSM, IR, timeout counter and output registers live in the top.

Test Plan:
- Reset, PC=5, memory returns 8'h3D after 0 wait -> IMEM_ADDR=5; CTRL_VALID at cycle 4 with RW=1, FS=0010, DA=AA=3, BA=1, PL=0.
- IMEM_RDY delayed 6 cycles, data 8'hE9 -> IMEM_REQ/IMEM_ADDR stable 7 cycles; EXEC with PL=1, JB=1, LAddress=2, RAddress=1.
- Opcodes C and D (8'hC6, 8'hD6) -> PL=1, BC=0 then PL=1, BC=1, LAddress=1, RAddress=2; sweep all 16 opcodes vs table.
- IMEM_RDY never asserted -> after 15 WAIT cycles FETCH_ERR=1, HALTED=1, IMEM_REQ=0; later RDY pulses ignored. RDY exactly at cycle 15 -> no error.
- Instruction 8'hF0 -> no CTRL_VALID, HALTED=1 forever; RST_N low releases to FETCH with all outputs 0.
- RST_N asserted asynchronously mid-WAIT (between edges) -> IMEM_REQ drops immediately; after release, a fresh fetch from current PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch/decode block.
//   - state_t    : controller states (FETCH, WAIT, DECODE, EXEC, HALT)
//   - OP_*       : 4-bit opcodes held in IR[7:4]
//   - FS_*       : ALU function-select codes
//   - *_HI/*_LO  : instruction field bit positions
//   - ctrl_t     : bundle of decoded control fields
package fetch_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        WAIT   = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOVA = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_ADI  = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_BRZ  = 4'hC;
    localparam logic [3:0] OP_BRN  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] FS_MOV   = 4'b0000;
    localparam logic [3:0] FS_INC   = 4'b0001;
    localparam logic [3:0] FS_ADD   = 4'b0010;
    localparam logic [3:0] FS_SUB   = 4'b0101;
    localparam logic [3:0] FS_AND   = 4'b1000;
    localparam logic [3:0] FS_OR    = 4'b1001;
    localparam logic [3:0] FS_XOR   = 4'b1010;
    localparam logic [3:0] FS_PASSB = 4'b1100;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 4;
    localparam int LA_HI  = 3;
    localparam int LA_LO  = 2;
    localparam int RA_HI  = 1;
    localparam int RA_LO  = 0;

    typedef struct packed {
        logic       pl;
        logic       jb;
        logic       bc;
        logic [1:0] la;
        logic [1:0] ra;
        logic [1:0] da;
        logic [1:0] aa;
        logic [1:0] ba;
        logic       mb;
        logic [3:0] fs;
        logic       md;
        logic       rw;
        logic       mw;
    } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational decode of an 8-bit instruction word.
// Ports:
//   i_ir              in   8  instruction register
//   o_pl/o_jb/o_bc    out  1  PC control (load, jump/branch select, branch cond)
//   o_la/o_ra         out  2  IR[3:2] / IR[1:0] (branch offset halves)
//   o_da/o_aa/o_ba    out  2  register addresses (dest, A, B)
//   o_mb              out  1  immediate on B bus
//   o_fs              out  4  ALU function select
//   o_md/o_rw/o_mw    out  1  memory-to-reg, reg write, mem write
//   o_halt            out  1  opcode is HALT
module instr_decoder
    import fetch_pkg::*;
(
    input  logic [7:0] i_ir,
    output logic       o_pl,
    output logic       o_jb,
    output logic       o_bc,
    output logic [1:0] o_la,
    output logic [1:0] o_ra,
    output logic [1:0] o_da,
    output logic [1:0] o_aa,
    output logic [1:0] o_ba,
    output logic       o_mb,
    output logic [3:0] o_fs,
    output logic       o_md,
    output logic       o_rw,
    output logic       o_mw,
    output logic       o_halt
);

    logic [3:0] w_opc;
    assign w_opc = i_ir[OPC_HI:OPC_LO];

    always_comb begin
        o_pl   = 1'b0;
        o_jb   = 1'b0;
        o_bc   = 1'b0;
        o_mb   = 1'b0;
        o_fs   = FS_MOV;
        o_md   = 1'b0;
        o_rw   = 1'b0;
        o_mw   = 1'b0;
        o_halt = 1'b0;
        // Register/offset fields are pure bit slices, independent of opcode.
        o_la   = i_ir[LA_HI:LA_LO];
        o_ra   = i_ir[RA_HI:RA_LO];
        o_da   = i_ir[LA_HI:LA_LO];
        o_aa   = i_ir[LA_HI:LA_LO];
        o_ba   = i_ir[RA_HI:RA_LO];
        case (w_opc)
            OP_NOP:  ;
            OP_MOVA: begin o_fs = FS_MOV;   o_rw = 1'b1; end
            OP_INC:  begin o_fs = FS_INC;   o_rw = 1'b1; end
            OP_ADD:  begin o_fs = FS_ADD;   o_rw = 1'b1; end
            OP_SUB:  begin o_fs = FS_SUB;   o_rw = 1'b1; end
            OP_AND:  begin o_fs = FS_AND;   o_rw = 1'b1; end
            OP_OR:   begin o_fs = FS_OR;    o_rw = 1'b1; end
            OP_XOR:  begin o_fs = FS_XOR;   o_rw = 1'b1; end
            OP_LDI:  begin o_fs = FS_PASSB; o_rw = 1'b1; o_mb = 1'b1; end
            OP_ADI:  begin o_fs = FS_ADD;   o_rw = 1'b1; o_mb = 1'b1; end
            OP_LD:   begin o_md = 1'b1;     o_rw = 1'b1; end
            OP_ST:   o_mw = 1'b1;
            OP_BRZ:  o_pl = 1'b1;
            OP_BRN:  begin o_pl = 1'b1; o_bc = 1'b1; end
            OP_JMP:  begin o_pl = 1'b1; o_jb = 1'b1; end
            OP_HALT: o_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: multi-cycle fetch/decode controller.
// Fetches the instruction at PC over a req/ready handshake, latches it in IR,
// decodes it and presents the controls for exactly one EXEC cycle.
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   PC        in  AW      current program counter
//   IMEM_REQ  out 1       fetch request, held until IMEM_RDY
//   IMEM_ADDR out AW      fetch address (PC captured at fetch start)
//   IMEM_RDY  in  1       instruction data valid
//   IMEM_DATA in  IW      instruction word
//   CTRL_VALID out 1      one-cycle strobe qualifying all control outputs
//   PL/JB/BC, LAddress/RAddress, DA/AA/BA, MB, FS, MD, RW, MW   decoded controls
//   HALTED    out 1       core halted (level)
//   FETCH_ERR out 1       sticky fetch timeout flag
module instr_fetch_decode
    import fetch_pkg::*;
#(
    parameter int AW      = 4,
    parameter int IW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [AW-1:0] PC,
    output logic          IMEM_REQ,
    output logic [AW-1:0] IMEM_ADDR,
    input  logic          IMEM_RDY,
    input  logic [IW-1:0] IMEM_DATA,
    output logic          CTRL_VALID,
    output logic          PL,
    output logic          JB,
    output logic          BC,
    output logic [1:0]    LAddress,
    output logic [1:0]    RAddress,
    output logic [1:0]    DA,
    output logic [1:0]    AA,
    output logic [1:0]    BA,
    output logic          MB,
    output logic [3:0]    FS,
    output logic          MD,
    output logic          RW,
    output logic          MW,
    output logic          HALTED,
    output logic          FETCH_ERR
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // A WAIT cycle without data that starts with this count pushes the
    // counter to TIMEOUT, i.e. it is the last cycle allowed.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        r_state,  w_state_nxt;
    logic [IW-1:0] r_ir,     w_ir_nxt;
    logic [CW-1:0] r_cnt,    w_cnt_nxt;
    logic [AW-1:0] r_addr,   w_addr_nxt;
    logic          r_req,    w_req_nxt;
    logic          r_valid,  w_valid_nxt;
    ctrl_t         r_ctrl,   w_ctrl_nxt;
    logic          r_halted, w_halted_nxt;
    logic          r_err,    w_err_nxt;

    logic       w_pl, w_jb, w_bc, w_mb, w_md, w_rw, w_mw, w_halt;
    logic [1:0] w_la, w_ra, w_da, w_aa, w_ba;
    logic [3:0] w_fs;
    ctrl_t      w_dec;

    instr_decoder u_dec (
        .i_ir   (r_ir),
        .o_pl   (w_pl),
        .o_jb   (w_jb),
        .o_bc   (w_bc),
        .o_la   (w_la),
        .o_ra   (w_ra),
        .o_da   (w_da),
        .o_aa   (w_aa),
        .o_ba   (w_ba),
        .o_mb   (w_mb),
        .o_fs   (w_fs),
        .o_md   (w_md),
        .o_rw   (w_rw),
        .o_mw   (w_mw),
        .o_halt (w_halt)
    );

    assign w_dec = {w_pl, w_jb, w_bc, w_la, w_ra, w_da, w_aa, w_ba,
                    w_mb, w_fs, w_md, w_rw, w_mw};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= FETCH;
            r_ir     <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
            r_ctrl   <= '0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ir     <= w_ir_nxt;
            r_cnt    <= w_cnt_nxt;
            r_addr   <= w_addr_nxt;
            r_req    <= w_req_nxt;
            r_valid  <= w_valid_nxt;
            r_ctrl   <= w_ctrl_nxt;
            r_halted <= w_halted_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ir_nxt     = r_ir;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = r_addr;
        w_req_nxt    = r_req;
        w_halted_nxt = r_halted;
        w_err_nxt    = r_err;
        // Controls and strobe are only ever loaded on the DECODE edge, so they
        // fall back to zero after the single EXEC cycle.
        w_valid_nxt  = 1'b0;
        w_ctrl_nxt   = '0;
        case (r_state)
            FETCH: begin
                w_addr_nxt  = PC;
                w_req_nxt   = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // Data has priority over the timeout in the final cycle.
                if (IMEM_RDY) begin
                    w_ir_nxt    = IMEM_DATA;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = DECODE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_err_nxt    = 1'b1;
                        w_halted_nxt = 1'b1;
                        w_req_nxt    = 1'b0;
                        w_state_nxt  = HALT;
                    end
                end
            end
            DECODE: begin
                if (w_halt) begin
                    w_halted_nxt = 1'b1;
                    w_state_nxt  = HALT;
                end else begin
                    w_ctrl_nxt  = w_dec;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC:    w_state_nxt = FETCH;
            HALT:    ;
            default: w_state_nxt = FETCH;
        endcase
    end

    assign IMEM_REQ   = r_req;
    assign IMEM_ADDR  = r_addr;
    assign CTRL_VALID = r_valid;
    assign PL         = r_ctrl.pl;
    assign JB         = r_ctrl.jb;
    assign BC         = r_ctrl.bc;
    assign LAddress   = r_ctrl.la;
    assign RAddress   = r_ctrl.ra;
    assign DA         = r_ctrl.da;
    assign AA         = r_ctrl.aa;
    assign BA         = r_ctrl.ba;
    assign MB         = r_ctrl.mb;
    assign FS         = r_ctrl.fs;
    assign MD         = r_ctrl.md;
    assign RW         = r_ctrl.rw;
    assign MW         = r_ctrl.mw;
    assign HALTED     = r_halted;
    assign FETCH_ERR  = r_err;

endmodule
